add_sub_sweep_checker: RTL and testbench
========================================

ADD_SUB_SWEEP_CHECKER -- requirements
Module: add_sub_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width driven to the adder/subtractor under test.
REQ-002 SHALL have parameter SETTLE, default 1, range 1-15, cycles between driving a vector and sampling the response.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a sweep.
REQ-006 SHALL have port a, output, WIDTH, operand A to the DUT.
REQ-007 SHALL have port b, output, WIDTH, operand B to the DUT.
REQ-008 SHALL have port c, output, 1, mode to the DUT: 0 = add, 1 = subtract.
REQ-009 SHALL have port s, input, WIDTH, DUT result.
REQ-010 SHALL have port cout, input, 1, DUT carry out.
REQ-011 SHALL have port busy, output, 1, high while a sweep runs.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at sweep end.
REQ-013 SHALL have port pass, output, 1, high when the last sweep had zero mismatches.
REQ-014 SHALL have port err_count, output, 2*WIDTH+2, mismatch count for the last or current sweep.
REQ-015 SHALL have port first_fail, output, 2*WIDTH+1, {c,a,b} of the first mismatching vector; zero if none.

Function
REQ-016 SHALL implement the FSM states IDLE, DRIVE, CHECK and DONE.
REQ-017 SHALL move IDLE->DRIVE on start; at that edge it loads vector {c,a,b}=0, clears err_count, first_fail and pass, and sets busy.
REQ-018 SHALL hold the vector for SETTLE cycles in DRIVE, then spend exactly one cycle in CHECK; each vector therefore takes SETTLE+1 cycles.
REQ-019 SHALL compute the expected result in CHECK as sum = a + (c ? ~b : b) + c, WIDTH+1 bits wide, with expected s = sum[WIDTH-1:0] and expected cout = sum[WIDTH].
REQ-020 SHALL treat a mismatch as s != expected s or cout != expected cout; on a mismatch it increments err_count, and the first mismatch of the sweep latches first_fail.
REQ-021 SHALL order the sweep with b innermost, then a, then c outermost; there are 2^(2*WIDTH+1) vectors in total (512 at default).
REQ-022 SHALL go CHECK->DRIVE with the incremented vector, except on the last vector {1,all-ones,all-ones}, where it goes CHECK->DONE.
REQ-023 SHALL, in DONE, pulse done for one cycle, clear busy, and set pass = (err_count == 0), then return to IDLE.
REQ-024 SHALL ignore start while busy, and SHALL ignore start in the DONE cycle.
REQ-025 SHALL hold a, b, c at their last values in IDLE; pass, err_count and first_fail are held until the next start.
REQ-026 SHALL count the mismatch from the final vector in err_count and pass.
REQ-027 SHALL NOT require err_count to saturate, since its width covers every vector.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, enter IDLE and force a, b, c, busy, done, pass, err_count and first_fail to 0.
REQ-029 SHALL give rst priority over start and abort any sweep in progress; no done pulse is produced for an aborted sweep.

Structure
REQ-030 SHALL place WIDTH default, state encoding (IDLE/DRIVE/CHECK/DONE), and mode constants MODE_ADD=0 and MODE_SUB=1 in shared package add_sub_pkg.
REQ-031 SHALL place the golden model in combinational sub-module add_sub_ref_model (inputs a, b, c; outputs exp_s, exp_cout), instantiated once.

Verification
REQ-032 SHALL pass this case: correct DUT, SETTLE=1, start pulse -> busy for 1024 cycles, one done pulse, pass=1, err_count=0, first_fail=0.
REQ-033 SHALL pass this case: DUT cout stuck at 0 -> err_count=256 (120 add carries + 136 subtract a>=b), pass=0, first_fail={0,4'd1,4'd15}.
REQ-034 SHALL pass this case: DUT s[0] inverted -> err_count=512, first_fail=0, pass=0.
REQ-035 SHALL pass this case: spot check at c=1, a=5, b=3 -> expected s=2, cout=1; at c=1, a=3, b=5 -> expected s=14, cout=0.
REQ-036 SHALL pass this case: start re-pulsed mid-sweep -> no restart; the sweep still completes in 1024 cycles.
REQ-037 SHALL pass this case: rst asserted 300 cycles into a sweep -> next cycle all outputs are 0, no done; a fresh start then gives a full, correct sweep.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/subtract sweep checker: default width,
// sweep FSM state encoding and adder mode constants.
package add_sub_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_sub_ref_model.sv
// Combinational golden model of a two's-complement adder/subtractor:
// subtract is formed as a + ~b + 1 so cout is the "no borrow" flag.
module add_sub_ref_model
  import add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] exp_s,
  output logic             exp_cout
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;

  // Select operand B polarity from the mode and form the WIDTH+1 bit sum.
  always_comb begin
    if (c == MODE_ADD) begin
      b_eff_s = b;
    end else begin
      b_eff_s = ~b;
    end
    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, c};
  end

  assign exp_s    = sum_s[WIDTH-1:0];
  assign exp_cout = sum_s[WIDTH];

endmodule

// File: rtl/add_sub_sweep_checker.sv
// Exhaustively sweeps {c,a,b} into an external adder/subtractor, waits SETTLE
// cycles per vector, and compares its result against the golden model.
module add_sub_sweep_checker
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 c,
  input  logic [WIDTH-1:0]     s,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int EW = 2 * WIDTH + 2;
  localparam logic [VW-1:0] VEC_ZERO    = {VW{1'b0}};
  localparam logic [VW-1:0] VEC_ONE     = VW'(1);
  localparam logic [VW-1:0] VEC_LAST    = {MODE_SUB, {(2 * WIDTH){1'b1}}};
  localparam logic [EW-1:0] ERR_ZERO    = {EW{1'b0}};
  localparam logic [EW-1:0] ERR_ONE     = EW'(1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  state_t        state_r, state_s;
  logic [VW-1:0] vec_r, vec_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic [EW-1:0] err_r, err_s;
  logic [VW-1:0] ff_r, ff_s;

  logic [WIDTH-1:0] exp_s_s;
  logic             exp_cout_s;
  logic             mismatch_s;

  assign c = vec_r[VW-1];
  assign a = vec_r[2*WIDTH-1:WIDTH];
  assign b = vec_r[WIDTH-1:0];

  add_sub_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a       (a),
    .b       (b),
    .c       (c),
    .exp_s   (exp_s_s),
    .exp_cout(exp_cout_s)
  );

  assign mismatch_s = (s != exp_s_s) || (cout != exp_cout_s);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    err_s   = err_r;
    ff_s    = ff_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = DRIVE;
          vec_s   = VEC_ZERO;
          cnt_s   = 4'd0;
          busy_s  = 1'b1;
          pass_s  = 1'b0;
          err_s   = ERR_ZERO;
          ff_s    = VEC_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = CHECK;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      CHECK: begin
        // err_r still zero here means this is the first mismatch of the sweep.
        if (mismatch_s) begin
          err_s = err_r + ERR_ONE;
          if (err_r == ERR_ZERO) begin
            ff_s = vec_r;
          end else begin
            ff_s = ff_r;
          end
        end else begin
          err_s = err_r;
        end
        if (vec_r == VEC_LAST) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_s == ERR_ZERO);
        end else begin
          state_s = DRIVE;
          vec_s   = vec_r + VEC_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= VEC_ZERO;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= ERR_ZERO;
      ff_r    <= VEC_ZERO;
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      err_r   <= err_s;
      ff_r    <= ff_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign first_fail = ff_r;

endmodule

// File: tb/tb_add_sub_sweep_checker.sv
// Directed bench: a behavioural adder/subtractor with injectable faults is
// swept by the checker; results are compared against hand-computed values.
module tb_add_sub_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       c;
  logic [3:0] s;
  logic       cout;
  logic       busy, done, pass;
  logic [9:0] err_count;
  logic [8:0] first_fail;

  logic [3:0] ra, rb, rs;
  logic       rc, rcout;

  int fault;
  int n_vec  = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  add_sub_sweep_checker #(.WIDTH(4), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .s         (s),
    .cout      (cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_fail(first_fail)
  );

  add_sub_ref_model #(.WIDTH(4)) spot (
    .a       (ra),
    .b       (rb),
    .c       (rc),
    .exp_s   (rs),
    .exp_cout(rcout)
  );

  // Device being swept: subtract expressed as difference plus a>=b flag.
  always_comb begin
    s    = 4'd0;
    cout = 1'b0;
    if (c) begin
      s    = a - b;
      cout = (a >= b);
    end else begin
      {cout, s} = {1'b0, a} + {1'b0, b};
    end
    if (fault == 1) cout = 1'b0;
    if (fault == 2) s[0] = ~s[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sweep(input int repulse_at, output int cycles);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    while (busy && cycles < 1100) begin
      start = (cycles == repulse_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(a), 32'd0);
    check({tag, "_b"}, 32'(b), 32'd0);
    check({tag, "_c"}, 32'(c), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_ff"}, 32'(first_fail), 32'd0);
  endtask

  initial begin
    fault = 0;
    rst   = 1'b1;
    start = 1'b0;
    ra = 4'd0; rb = 4'd0; rc = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Golden model spot checks.
    ra = 4'd5; rb = 4'd3; rc = 1'b1; #1;
    check("spot_5m3_s", 32'(rs), 32'd2);
    check("spot_5m3_cout", 32'(rcout), 32'd1);
    ra = 4'd3; rb = 4'd5; rc = 1'b1; #1;
    check("spot_3m5_s", 32'(rs), 32'd14);
    check("spot_3m5_cout", 32'(rcout), 32'd0);
    ra = 4'd9; rb = 4'd8; rc = 1'b0; #1;
    check("spot_9p8_s", 32'(rs), 32'd1);
    check("spot_9p8_cout", 32'(rcout), 32'd1);

    // Clean sweep.
    sweep(-1, cyc);
    check("clean_cycles", 32'(cyc), 32'd1024);
    check("clean_done", 32'(done), 32'd1);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_ff", 32'(first_fail), 32'd0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("hold_a", 32'(a), 32'd15);
    check("hold_b", 32'(b), 32'd15);
    check("hold_c", 32'(c), 32'd1);

    // Carry out stuck at zero.
    fault = 1;
    sweep(-1, cyc);
    check("cout0_cycles", 32'(cyc), 32'd1024);
    check("cout0_err", 32'(err_count), 32'd256);
    check("cout0_pass", 32'(pass), 32'd0);
    check("cout0_ff", 32'(first_fail), 32'h01F);

    // Result bit 0 inverted.
    fault = 2;
    sweep(-1, cyc);
    check("s0inv_err", 32'(err_count), 32'd512);
    check("s0inv_pass", 32'(pass), 32'd0);
    check("s0inv_ff", 32'(first_fail), 32'd0);

    // Start re-pulsed mid-sweep.
    fault = 0;
    sweep(100, cyc);
    check("repulse_cycles", 32'(cyc), 32'd1024);
    check("repulse_pass", 32'(pass), 32'd1);
    check("repulse_err", 32'(err_count), 32'd0);

    // Reset 300 cycles into a sweep.
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (299) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_all_zero("abort");
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    fault = 0;
    sweep(-1, cyc);
    check("post_abort_cycles", 32'(cyc), 32'd1024);
    check("post_abort_done", 32'(done), 32'd1);
    check("post_abort_pass", 32'(pass), 32'd1);
    check("post_abort_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
